// File: rtl/inst_mem_loader.sv
// inst_mem_loader: writes a program image, received as a little-endian byte stream,
// into the instruction RAM and holds the core in reset until the image is complete.
//
// Image format: a 32-bit word count N (4 bytes, LSB first), then N words (4 bytes each,
// LSB first). Word i is written to BASE_ADDR + 4*i.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-high
//   byte_valid_i  byte_i holds a valid byte
//   byte_i        stream byte
//   byte_ready_o  loader accepts a byte this cycle (registered)
//   reload_i      restart a load; honoured only once loading has finished or failed
//   mem_we_o      instruction RAM write strobe, one cycle per word
//   mem_addr_o    byte address of the word being written
//   mem_data_o    word being written
//   cpu_rst_o     active-high reset to the core; low only after a complete image
//   done_o        image loaded, core released
//   err_o         header word count exceeded MAX_WORDS
module inst_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    input  logic        reload_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StHdr,
        StCheck,
        StData,
        StWrite,
        StDone,
        StErr
    } state_t;

    state_t           state;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] word_cnt;
    logic [23:0]      asm_word;   // low three bytes; the fourth comes straight from byte_i
    logic [31:0]      hdr_n;

    logic        take;
    logic        last_byte;
    logic [31:0] word_full;
    logic [31:0] word_offset;
    logic        last_word;

    always_comb begin
        take        = byte_valid_i & byte_ready_o;
        last_byte   = (byte_idx == 2'd3);
        word_full   = {byte_i, asm_word};
        word_offset = 32'({word_cnt, 2'b00});
        last_word   = ((32'(word_cnt) + 32'd1) == hdr_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StHdr;
            byte_idx     <= 2'd0;
            word_cnt     <= '0;
            asm_word     <= '0;
            hdr_n        <= '0;
            byte_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= BASE_ADDR;
            mem_data_o   <= '0;
            cpu_rst_o    <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            unique case (state)
                StHdr, StData: begin
                    byte_ready_o <= 1'b1;
                    if (take) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    asm_word[7:0]   <= byte_i;
                            2'd1:    asm_word[15:8]  <= byte_i;
                            2'd2:    asm_word[23:16] <= byte_i;
                            default: ;
                        endcase
                        if (last_byte) begin
                            // Drop ready now so the bubble cycle never sees a handshake.
                            byte_ready_o <= 1'b0;
                            if (state == StHdr) begin
                                hdr_n <= word_full;
                                state <= StCheck;
                            end else begin
                                mem_we_o   <= 1'b1;
                                mem_data_o <= word_full;
                                mem_addr_o <= BASE_ADDR + word_offset;
                                state      <= StWrite;
                            end
                        end
                    end
                end
                StCheck: begin
                    byte_ready_o <= 1'b0;
                    if (hdr_n == 32'd0) begin
                        state     <= StDone;
                        cpu_rst_o <= 1'b0;
                        done_o    <= 1'b1;
                    end else if (hdr_n > 32'(MAX_WORDS)) begin
                        state <= StErr;
                        err_o <= 1'b1;
                    end else begin
                        state        <= StData;
                        word_cnt     <= '0;
                        byte_ready_o <= 1'b1;
                    end
                end
                StWrite: begin
                    word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_word) begin
                        state        <= StDone;
                        byte_ready_o <= 1'b0;
                        cpu_rst_o    <= 1'b0;
                        done_o       <= 1'b1;
                    end else begin
                        state        <= StData;
                        byte_ready_o <= 1'b1;
                    end
                end
                StDone, StErr: begin
                    byte_ready_o <= 1'b0;
                    if (reload_i) begin
                        state        <= StHdr;
                        byte_ready_o <= 1'b1;
                        cpu_rst_o    <= 1'b1;
                        done_o       <= 1'b0;
                        err_o        <= 1'b0;
                        word_cnt     <= '0;
                        byte_idx     <= 2'd0;
                    end
                end
                default: begin
                    state        <= StHdr;
                    byte_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: a byte-count model of the loading protocol is checked against
// the DUT outputs on every falling edge, plus literal expectations after each scenario.
module tb_inst_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_d = 8'h00;
    logic        reload = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    inst_mem_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .CNT_W(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .byte_valid_i(byte_valid),
        .byte_i(byte_d),
        .byte_ready_o(byte_ready),
        .reload_i(reload),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_data_o(mem_data),
        .cpu_rst_o(cpu_rst),
        .done_o(done),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Protocol model: counts accepted bytes of the current load. m_fin: 0 loading, 1 done,
    // 2 error. m_bubble marks the single no-accept cycle after each completed 4-byte group.
    bit          m_live   = 1'b0;
    int          m_cnt    = 0;
    int          m_words  = 0;
    bit          m_bubble = 1'b0;
    int          m_fin    = 0;
    bit          m_we     = 1'b0;
    logic [31:0] m_addr   = BASE;
    logic [31:0] m_data   = 32'h0;
    logic [31:0] m_n      = 32'h0;
    logic [31:0] m_word   = 32'h0;
    int          m_k;
    bit          m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_live = 1'b0; m_cnt = 0; m_words = 0; m_bubble = 1'b0; m_fin = 0;
            m_we = 1'b0; m_addr = BASE; m_data = 32'h0; m_n = 32'h0; m_word = 32'h0;
        end else begin
            m_acc  = byte_valid && m_live && (m_fin == 0) && !m_bubble;
            m_live = 1'b1;
            if (m_bubble) begin
                m_bubble = 1'b0;
                if (m_we) begin
                    m_we = 1'b0;
                    m_words++;
                    if (m_words == m_n) m_fin = 1;
                end else if (m_n == 32'd0) begin
                    m_fin = 1;
                end else if (m_n > MAXW) begin
                    m_fin = 2;
                end
            end else if (m_fin != 0) begin
                if (reload) begin
                    m_fin = 0; m_cnt = 0; m_words = 0;
                end
            end else if (m_acc) begin
                m_k = m_cnt % 4;
                if (m_k == 0) m_word = 32'h0;
                m_word = m_word | (32'(byte_d) << (8 * m_k));
                m_cnt++;
                if (m_cnt == 4) begin
                    m_n = m_word;
                    m_bubble = 1'b1;
                end else if (m_k == 3) begin
                    m_we = 1'b1;
                    m_addr = BASE + 32'(4 * m_words);
                    m_data = m_word;
                    m_bubble = 1'b1;
                end
            end
        end
    end

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        check("ready", {31'h0, byte_ready}, {31'h0, m_live && (m_fin == 0) && !m_bubble});
        check("we", {31'h0, mem_we}, {31'h0, m_we});
        check("addr", mem_addr, m_addr);
        check("data", mem_data, m_data);
        check("cpu_rst", {31'h0, cpu_rst}, {31'h0, m_fin != 1});
        check("done", {31'h0, done}, {31'h0, m_fin == 1});
        check("err", {31'h0, err}, {31'h0, m_fin == 2});
        check("done_err_excl", {31'h0, done & err}, 32'h0);
        if (mem_we === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        byte_d = b;
        while (!acc) begin
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = byte_valid && byte_ready;
            tick();
            guard++;
            if (guard > 200) begin
                check("byte_timeout", 32'h0, 32'h1);
                acc = 1'b1;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send(t[7:0], rnd);
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done !== 1'b1 && err !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        check("wait_done", {31'h0, done}, 32'h1);
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        reload = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_ready", {31'h0, byte_ready}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_addr", mem_addr, BASE);
        check("rst_data", mem_data, 32'h0);
        check("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("ready_after_rst", {31'h0, byte_ready}, 32'h1);
    endtask

    int mark;
    int accepted;

    initial begin
        #2 do_reset();

        // Two-word image.
        mark = log_addr.size();
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        wait_done();
        check("t1_nwrites", 32'(log_addr.size() - mark), 32'd2);
        check("t1_addr0", log_addr[mark], 32'h0000_0000);
        check("t1_data0", log_data[mark], 32'h0000_0013);
        check("t1_addr1", log_addr[mark+1], 32'h0000_0004);
        check("t1_data1", log_data[mark+1], 32'h0010_0093);
        check("t1_cpu_rst", {31'h0, cpu_rst}, 32'h0);

        // Empty image: CHECK cycle, then DONE.
        do_reset();
        mark = log_addr.size();
        send_word(32'd0, 1'b0);
        check("t2_done_in_check", {31'h0, done}, 32'h0);
        tick();
        check("t2_done", {31'h0, done}, 32'h1);
        check("t2_nwrites", 32'(log_addr.size() - mark), 32'd0);

        // Oversized header.
        do_reset();
        send(8'h01, 1'b0); send(8'h04, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        tick();
        check("t3_err", {31'h0, err}, 32'h1);
        check("t3_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check("t3_ready", {31'h0, byte_ready}, 32'h0);
        accepted = 0;
        byte_d = 8'h55;
        byte_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (byte_valid && byte_ready) accepted++;
            tick();
        end
        byte_valid = 1'b0;
        check("t3_no_accept", 32'(accepted), 32'd0);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("t3_err_cleared", {31'h0, err}, 32'h0);
        check("t3_ready_hdr", {31'h0, byte_ready}, 32'h1);

        // Two-word image with gappy valid.
        do_reset();
        mark = log_addr.size();
        send_word(32'd2, 1'b1);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        wait_done();
        check("t4_nwrites", 32'(log_addr.size() - mark), 32'd2);
        check("t4_data0", log_data[mark], 32'h0000_0013);
        check("t4_addr1", log_addr[mark+1], 32'h0000_0004);
        check("t4_data1", log_data[mark+1], 32'h0010_0093);

        // Reset mid-word, then a fresh one-word image.
        do_reset();
        send_word(32'd3, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        do_reset();
        mark = log_addr.size();
        send_word(32'd1, 1'b0);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
        wait_done();
        check("t5_nwrites", 32'(log_addr.size() - mark), 32'd1);
        check("t5_addr", log_addr[mark], BASE);
        check("t5_data", log_data[mark], 32'hDDCC_BBAA);

        // Reload from DONE; a reload pulse mid-header is ignored.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("t6_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check("t6_done", {31'h0, done}, 32'h0);
        mark = log_addr.size();
        send(8'h01, 1'b0);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send_word(32'h0, 1'b0);
        wait_done();
        check("t6_nwrites", 32'(log_addr.size() - mark), 32'd1);
        check("t6_addr", log_addr[mark], BASE);
        check("t6_data", log_data[mark], 32'h0);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer for the instruction memory that the core fetches from.
- Receives a program image as a byte stream (ready/valid) and assembles little-endian 32-bit words.
- Issues single-cycle write strobes into the instruction RAM.
- Holds the core in reset until the image is complete. It sits in the SOPC between the host byte link and the instruction RAM write port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word.
- MAX_WORDS, 1024, instruction RAM depth in words; a larger header count is an error.
- CNT_W, 11, width of the word counter; must hold MAX_WORDS.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- byte_valid_i  input  1  byte_i holds a valid byte
- byte_i  input  8  stream byte
- byte_ready_o  output  1  loader accepts a byte this cycle
- reload_i  input  1  pulse in DONE/ERR: restart a load
- mem_we_o  output  1  instruction RAM write strobe, one cycle per word
- mem_addr_o  output  32  byte address of the word being written
- mem_data_o  output  32  word being written
- cpu_rst_o  output  1  active-high reset to the eriscv core
- done_o  output  1  image loaded, core released
- err_o  output  1  header count exceeded MAX_WORDS

Behaviour:
- Reset is asynchronous, active-high. On assertion:
  - state=HDR, byte index=0, word counter=0, assembly register=0.
  - byte_ready_o=0 while rst is high; it goes to 1 from the first clock after release.
  - mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, cpu_rst_o=1, done_o=0, err_o=0.
  - Reset mid-load abandons the partial image; words already written are not undone.
- A byte transfer happens on a rising edge where byte_valid_i & byte_ready_o. byte_ready_o is registered and is 1 only in HDR and DATA.
- Assembly: the byte at index k (0..3) goes to bits [8k+7:8k], little-endian. The index wraps 3->0 on the 4th byte.
- States:
  - HDR: collect 4 bytes into the header word count N. On the 4th byte, go to CHECK.
  - CHECK (1 cycle, ready=0):
    - N==0 -> DONE.
    - N>MAX_WORDS -> ERR.
    - Otherwise -> DATA, with counter=0.
  - DATA: collect 4 bytes. On the 4th byte, go to WRITE.
  - WRITE (1 cycle, ready=0):
    - mem_we_o=1, mem_data_o=assembled word, mem_addr_o=BASE_ADDR+4*counter.
    - Counter increments.
    - counter+1==N -> DONE; else -> DATA.
  - DONE: cpu_rst_o=0 and done_o=1, both registered and valid from the first cycle in DONE; ready=0.
  - ERR: err_o=1, cpu_rst_o stays 1, ready=0, input bytes are ignored.
- Write timing:
  - The write strobe is asserted in the cycle after the 4th data byte is accepted.
  - mem_we_o is high for exactly one cycle per word.
  - mem_addr_o and mem_data_o hold their values after the strobe until the next write.
- Address arithmetic is modulo 2^32. MAX_WORDS bounds the address span, so no wrap occurs in range.
- reload_i is honoured only in DONE or ERR. Next cycle: state=HDR, cpu_rst_o=1, done_o=0, err_o=0, counter=0, byte index=0. In HDR/DATA, reload_i is ignored.
- byte_valid_i while ready=0 is not consumed; the source must hold the byte (standard ready/valid).
- If valid drops mid-word, the partial assembly is kept; there is no timeout.
- done_o and err_o are never high together.

Test Plan:
- Reset, then stream header 02 00 00 00, words 13 00 00 00 and 93 00 10 00:
  - Exactly two writes: (0x0000_0000, 0x0000_0013) then (0x0000_0004, 0x0010_0093), each with mem_we_o=1 for one cycle.
  - Then done_o=1, cpu_rst_o=0.
- Header 00 00 00 00:
  - No write.
  - done_o=1 two cycles after the 4th header byte (CHECK, then DONE).
- Header 01 04 00 00 (N=1025 > MAX_WORDS):
  - err_o=1, cpu_rst_o=1, byte_ready_o=0.
  - Further bytes are not accepted.
  - A reload_i pulse returns to HDR with err_o=0.
- Same 2-word image with byte_valid_i toggling randomly:
  - Identical writes and data.
  - byte_ready_o=0 in every CHECK/WRITE cycle, and no byte is lost or duplicated.
- Assert rst after the 2nd data byte of word 1 (N=3), then send a fresh 1-word image AA BB CC DD:
  - All outputs return to reset values immediately.
  - Write (BASE_ADDR, 0xDDCC_BBAA), then DONE.
- In DONE, pulse reload_i and load a 1-word image 00 00 00 00:
  - cpu_rst_o=1 and done_o=0 from the cycle after reload_i.
  - Write (BASE_ADDR, 0x0), then DONE again.
